// File: rtl/ir_adc_reader.sv
// ADC0831-style serial front end: one conversion per SAMPLE_PERIOD clocks, result
// deserialised MSB-first and presented to FIR_IR with a one-cycle Sample_Valid strobe.
module ir_adc_reader #(
  parameter int CLK_DIV       = 2,
  parameter int LEAD_BITS     = 1,
  parameter int DATA_W        = 8,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic              CLK_Filter,
  input  logic              rst,
  input  logic              Enable,
  input  logic              ADC_DOUT,
  output logic              ADC_CS_n,
  output logic              ADC_SCLK,
  output logic [DATA_W-1:0] IR_ADC_Value,
  output logic              Sample_Valid,
  output logic              Busy,
  output logic              Overrun
);

  localparam int NBITS = LEAD_BITS + DATA_W;
  localparam int TW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW    = $clog2(NBITS + 1);

  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NBITS - 1);
  localparam logic [BW-1:0] B_LEAD = BW'(LEAD_BITS);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, DONE} state_t;

  state_t            state, state_d;
  logic [TW-1:0]     timer;
  logic [DW-1:0]     div_cnt, div_cnt_d;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic              sclk_d, cs_n_d;
  logic              sample_en, load_en;
  logic              tick;
  logic [DATA_W-1:0] shreg;

  assign tick = Enable && (timer == T_LAST);
  assign Busy = (state != IDLE);

  always_comb begin
    state_d   = state;
    div_cnt_d = div_cnt;
    bit_cnt_d = bit_cnt;
    sclk_d    = ADC_SCLK;
    cs_n_d    = ADC_CS_n;
    sample_en = 1'b0;
    load_en   = 1'b0;
    unique case (state)
      IDLE: begin
        cs_n_d    = 1'b1;
        sclk_d    = 1'b0;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        if (tick) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
        end
      end
      CS_SETUP: begin
        if (div_cnt == D_LAST) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt != D_LAST) begin
          div_cnt_d = div_cnt + 1'b1;
        end else begin
          div_cnt_d = '0;
          // Rising event samples DOUT; falling event advances the bit or finishes.
          if (!ADC_SCLK) begin
            sclk_d    = 1'b1;
            sample_en = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == B_LAST) begin
              state_d = DONE;
              cs_n_d  = 1'b1;
              load_en = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_Filter) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      ADC_CS_n     <= 1'b1;
      ADC_SCLK     <= 1'b0;
      IR_ADC_Value <= '0;
      Sample_Valid <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      state        <= state_d;
      div_cnt      <= div_cnt_d;
      bit_cnt      <= bit_cnt_d;
      ADC_CS_n     <= cs_n_d;
      ADC_SCLK     <= sclk_d;
      Sample_Valid <= load_en;
      if (!Enable || timer == T_LAST) timer <= '0;
      else                            timer <= timer + 1'b1;
      if (tick && state != IDLE) Overrun <= 1'b1;
      if (load_en) IR_ADC_Value <= shreg;
    end
  end

  // Lead (start/null) bits are sampled but never reach the shift register.
  always_ff @(posedge CLK_Filter) begin
    if (sample_en && bit_cnt >= B_LEAD) shreg <= {shreg[DATA_W-2:0], ADC_DOUT};
  end

endmodule

// File: tb/tb_ir_adc_reader.sv
// Bench for ir_adc_reader: ADC serial models, a conversion-schedule model checked every
// cycle, and directed scenarios with literal expectations (second instance for overrun).
module tb_ir_adc_reader;
  localparam int CLK_DIV   = 2;
  localparam int LEAD_BITS = 1;
  localparam int DATA_W    = 8;
  localparam int SP        = 100;
  localparam int SP2       = 30;
  localparam int NB        = LEAD_BITS + DATA_W;
  localparam int CONV_LEN  = CLK_DIV + 2 * CLK_DIV * NB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, dout, cs_n, sclk, vld, busy, ovr;
  logic [DATA_W-1:0] val;
  logic              rst2, en2, dout2, cs2, sclk2, vld2, busy2, ovr2;
  logic [DATA_W-1:0] val2;

  ir_adc_reader #(.CLK_DIV(CLK_DIV), .LEAD_BITS(LEAD_BITS), .DATA_W(DATA_W),
                  .SAMPLE_PERIOD(SP)) dut (
    .CLK_Filter(clk), .rst(rst), .Enable(en), .ADC_DOUT(dout),
    .ADC_CS_n(cs_n), .ADC_SCLK(sclk), .IR_ADC_Value(val),
    .Sample_Valid(vld), .Busy(busy), .Overrun(ovr));

  ir_adc_reader #(.CLK_DIV(CLK_DIV), .LEAD_BITS(LEAD_BITS), .DATA_W(DATA_W),
                  .SAMPLE_PERIOD(SP2)) dut_ovr (
    .CLK_Filter(clk), .rst(rst2), .Enable(en2), .ADC_DOUT(dout2),
    .ADC_CS_n(cs2), .ADC_SCLK(sclk2), .IR_ADC_Value(val2),
    .Sample_Valid(vld2), .Busy(busy2), .Overrun(ovr2));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // ADC models: present a start bit of 1 then the word MSB-first; advance on SCLK fall.
  logic [DATA_W-1:0] adc_word, adc_word2;
  logic [NB-1:0]     adc_sr, adc_sr2;
  always @(negedge cs_n)  adc_sr  <= {{LEAD_BITS{1'b1}}, adc_word};
  always @(negedge sclk)  adc_sr  <= adc_sr << 1;
  always @(negedge cs2)   adc_sr2 <= {{LEAD_BITS{1'b1}}, adc_word2};
  always @(negedge sclk2) adc_sr2 <= adc_sr2 << 1;
  assign dout  = cs_n ? 1'b0 : adc_sr[NB-1];
  assign dout2 = cs2  ? 1'b0 : adc_sr2[NB-1];

  int sclk_rises = 0;
  always @(posedge sclk) sclk_rises <= sclk_rises + 1;

  // Schedule model: m_k is the clock index inside a conversion (0 = idle).
  int                m_tmr = 0;
  int                m_k   = 0;
  logic [DATA_W-1:0] m_val = '0;
  logic [DATA_W-1:0] m_word = '0;
  logic              m_ovr = 1'b0;
  logic              m_ok  = 1'b0;
  logic              m_tick;
  assign m_tick = en && (m_tmr == SP - 1);

  always @(posedge clk) begin
    if (rst) begin
      m_tmr <= 0; m_k <= 0; m_val <= '0; m_ovr <= 1'b0; m_ok <= 1'b1;
    end else if (m_ok) begin
      m_tmr <= (en && m_tmr != SP - 1) ? m_tmr + 1 : 0;
      m_k   <= (m_tick && m_k == 0) ? 1 : (m_k == 0 || m_k == CONV_LEN) ? 0 : m_k + 1;
      if (m_tick && m_k != 0) m_ovr <= 1'b1;
      if (m_tick && m_k == 0) m_word <= adc_word;
      if (m_k == CONV_LEN - 1) m_val <= m_word;
    end
  end

  logic exp_cs, exp_sclk;
  assign exp_cs   = (m_k == 0) || (m_k == CONV_LEN);
  assign exp_sclk = (m_k > CLK_DIV) && (m_k < CONV_LEN) && (((m_k - CLK_DIV - 1) / CLK_DIV) % 2 == 1);

  always @(negedge clk) begin
    if (m_ok) begin
      check("cs_n",     32'(cs_n), 32'(exp_cs));
      check("sclk",     32'(sclk), 32'(exp_sclk));
      check("valid",    32'(vld),  32'(m_k == CONV_LEN));
      check("busy",     32'(busy), 32'(m_k != 0));
      check("value",    32'(val),  32'(m_val));
      check("overrun",  32'(ovr),  32'(m_ovr));
    end
  end

  task automatic wait_valid(input int bound, output int at);
    at = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
      if (vld) begin at = i; break; end
    end
  endtask

  task automatic wait_cs_low(input int bound, output int at);
    at = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
      if (!cs_n) begin at = i; break; end
    end
  endtask

  initial begin
    int first_cs, at, r0, rises, cs_falls;
    logic prev;
    rst = 1'b1; en = 1'b1; adc_word = 8'd200;
    rst2 = 1'b1; en2 = 1'b0; adc_word2 = 8'hB7;

    // Reset held 3 clocks with Enable=1
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_value", 32'(val), 32'd0);
    check("rst_valid", 32'(vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(ovr), 32'd0);
    check("rst_sclk_edges", 32'(sclk_rises), 32'd0);

    // Single sample of 200
    @(negedge clk); rst = 1'b0;
    r0 = sclk_rises; first_cs = 0; at = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (!cs_n && first_cs == 0) first_cs = i;
      if (vld) begin at = i; break; end
    end
    check("first_cs_fall_edge", 32'(first_cs), 32'd100);
    check("valid_edge", 32'(at), 32'd138);
    check("tick_to_valid", 32'(at - first_cs + 1), 32'd39);
    check("sample_200", 32'(val), 32'd200);
    check("sclk_rises_per_conv", 32'(sclk_rises - r0), 32'd9);

    // Stream: 100 follows 200, 100 clocks apart
    adc_word = 8'd100;
    wait_valid(150, at);
    check("valid_spacing", 32'(at), 32'd100);
    check("sample_100", 32'(val), 32'd100);

    // Reset on the 5th SCLK rise of the next conversion
    wait_cs_low(120, at);
    check("cs_fall_before_abort", 32'(at != 0), 32'd1);
    rises = 0; prev = sclk;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 5) break;
    end
    check("fifth_rise_seen", 32'(rises), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_value", 32'(val), 32'd0);
    @(negedge clk); rst = 1'b0; adc_word = 8'h5A;
    wait_valid(200, at);
    check("post_abort_valid_edge", 32'(at), 32'd138);
    check("post_abort_sample", 32'(val), 32'h5A);

    // Enable dropped mid-conversion, then re-enabled
    adc_word = 8'h3C;
    wait_cs_low(120, at);
    check("cs_fall_before_disable", 32'(at != 0), 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk); en = 1'b0;
    wait_valid(60, at);
    check("disabled_conv_completes", 32'(at != 0), 32'd1);
    check("disabled_sample", 32'(val), 32'h3C);
    cs_falls = 0; prev = cs_n;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (!cs_n && prev) cs_falls++;
      prev = cs_n;
    end
    check("no_cs_while_disabled", 32'(cs_falls), 32'd0);
    adc_word = 8'hA5;
    @(negedge clk); en = 1'b1;
    wait_cs_low(150, at);
    check("reenable_first_cs_edge", 32'(at), 32'd100);
    wait_valid(60, at);
    check("reenable_sample", 32'(val), 32'hA5);

    // Overrun instance: SAMPLE_PERIOD shorter than a conversion
    @(negedge clk); rst2 = 1'b0; en2 = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      @(posedge clk); #1;
      if (i == 30) begin
        check("ovr_cs_fall", 32'(cs2), 32'd0);
        adc_word2 = 8'h4E;
      end
      if (i == 59)  check("ovr_before_drop", 32'(ovr2), 32'd0);
      if (i == 60)  check("ovr_after_drop", 32'(ovr2), 32'd1);
      if (i == 68)  check("ovr_valid1", 32'(vld2), 32'd1);
      if (i == 68)  check("ovr_sample1", 32'(val2), 32'hB7);
      if (i == 127) check("ovr_hold1", 32'(val2), 32'hB7);
      if (i == 128) check("ovr_valid2", 32'(vld2), 32'd1);
      if (i == 128) check("ovr_sample2", 32'(val2), 32'h4E);
      if (i == 130) check("ovr_sticky", 32'(ovr2), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
